// File: rtl/vrf_wr_sched_if.sv
// Bundle between the retire/preload producers and the VRF write scheduler.
// It carries the request handshakes plus the registered full-file write views.
interface vrf_wr_sched_if #(
    parameter int VLEN    = 128,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][4:0]            req_vd;
    logic [NUM_REQ-1:0][VLEN/8-1:0]     req_be;
    logic [NUM_REQ-1:0][VLEN-1:0]       req_data;
    logic [NUM_REQ-1:0]                 req_last;

    logic                               pl_valid;
    logic                               pl_ready;
    logic [4:0]                         pl_idx;
    logic [VLEN-1:0]                    pl_data;

    logic [31:0][VLEN-1:0]              vrf_wr_wenb_full;
    logic [31:0][VLEN-1:0]              vrf_wr_data_full;
    logic [NUM_REQ-1:0]                 rt_uop;
    logic [NUM_REQ-1:0]                 rt_last_uop;

    modport master (
        output req_valid, req_vd, req_be, req_data, req_last,
        output pl_valid, pl_idx, pl_data,
        input  req_ready, pl_ready,
        input  vrf_wr_wenb_full, vrf_wr_data_full, rt_uop, rt_last_uop
    );

    modport slave (
        input  req_valid, req_vd, req_be, req_data, req_last,
        input  pl_valid, pl_idx, pl_data,
        output req_ready, pl_ready,
        output vrf_wr_wenb_full, vrf_wr_data_full, rt_uop, rt_last_uop
    );
endinterface

// File: rtl/vrf_wr_sched.sv
// VRF write scheduler: in-order retire grants with same-register byte merge,
// plus a preload path that owns the write port for one cycle and a gap cycle.
module vrf_wr_sched #(
    parameter int VLEN    = 128,
    parameter int NUM_REQ = 4,
    parameter int NUM_WP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    vrf_wr_sched_if.slave    bus
);
    localparam int NB = VLEN / 8;

    typedef enum logic [1:0] {IDLE, PL_WR, PL_GAP} state_t;

    state_t                     state, state_n;
    logic [NUM_REQ-1:0]         grant;
    logic                       accept;
    logic                       run;
    logic [31:0][VLEN-1:0]      wenb_n, data_n, wenb_q, data_q;
    logic [NUM_REQ-1:0]         rt_q, rt_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Preload beats retire in IDLE; grants are otherwise the valid prefix capped at NUM_WP.
    always_comb begin
        state_n = state;
        grant   = '0;
        accept  = 1'b0;
        run     = 1'b1;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (bus.pl_valid) begin
                        accept  = 1'b1;
                        state_n = PL_WR;
                    end else begin
                        for (int i = 0; i < NUM_REQ; i++) begin
                            run = run & bus.req_valid[i];
                            if (i < NUM_WP) grant[i] = run;
                        end
                    end
                end
            end
            PL_WR:   state_n = PL_GAP;
            PL_GAP:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.req_ready = grant;
    assign bus.pl_ready  = (state == IDLE) && !rst;

    // Ascending lane order lets the highest granted lane own each byte it enables.
    always_comb begin
        wenb_n = '0;
        data_n = '0;
        if (accept) begin
            wenb_n[bus.pl_idx] = '1;
            data_n[bus.pl_idx] = bus.pl_data;
        end
        for (int l = 0; l < NUM_REQ; l++) begin
            if (grant[l]) begin
                for (int k = 0; k < NB; k++) begin
                    if (bus.req_be[l][k]) begin
                        wenb_n[bus.req_vd[l]][k*8 +: 8] = 8'hFF;
                        data_n[bus.req_vd[l]][k*8 +: 8] = bus.req_data[l][k*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wenb_q    <= '0;
            data_q    <= '0;
            rt_q      <= '0;
            rt_last_q <= '0;
        end else begin
            wenb_q    <= wenb_n;
            data_q    <= data_n;
            rt_q      <= grant;
            rt_last_q <= grant & bus.req_last;
        end
    end

    assign bus.vrf_wr_wenb_full = wenb_q;
    assign bus.vrf_wr_data_full = data_q;
    assign bus.rt_uop           = rt_q;
    assign bus.rt_last_uop      = rt_last_q;
endmodule

// File: doc/vrf_wr_sched.md
Name: vrf_wr_sched

Overview:
- Write-side controller for the backend vector register file (32 x VLEN).
- Accepts in-order retire write requests from NUM_REQ retire lanes and a backdoor preload port.
- Grants up to NUM_WP writes per cycle, byte-merges same-register writes, and drives registered full-file write-enable/data views to the VRF.
- Emits per-lane retire pulses (rt_uop, rt_last_uop).

Parameters:
- VLEN, 128, vector register width in bits; multiple of 8.
- NUM_REQ, 4, retire request lanes; lane 0 is oldest.
- NUM_WP, 2, maximum retire writes granted per cycle; 1 <= NUM_WP <= NUM_REQ.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  retire write request per lane.
- req_ready  out  NUM_REQ  grant per lane; combinational from state and req_valid.
- req_vd  in  NUM_REQ*5  destination register index per lane.
- req_be  in  NUM_REQ*(VLEN/8)  byte enables per lane.
- req_data  in  NUM_REQ*VLEN  write data per lane.
- req_last  in  NUM_REQ  request is the last uop of its instruction.
- pl_valid  in  1  preload request.
- pl_ready  out  1  preload accepted.
- pl_idx  in  5  preload register index.
- pl_data  in  VLEN  preload data; preload writes all bytes.
- vrf_wr_wenb_full  out  32*VLEN  registered bit-level write enable per register.
- vrf_wr_data_full  out  32*VLEN  registered write data per register.
- rt_uop  out  NUM_REQ  registered retire pulse per lane.
- rt_last_uop  out  NUM_REQ  registered last-uop retire pulse per lane.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - vrf_wr_wenb_full, vrf_wr_data_full, rt_uop, rt_last_uop all 0.
  - req_ready=0 and pl_ready=0 while rst is high.
- FSM states: IDLE, PL_WR, PL_GAP.
- IDLE:
  - pl_ready=1.
  - If pl_valid, the preload is accepted, all req_ready=0 that cycle (preload wins), and the next state is PL_WR.
  - Otherwise retire grants apply.
- PL_WR:
  - Outputs drive reg pl_idx: wenb all-ones, data=pl_data captured at accept. All other registers have wenb=0.
  - req_ready=0, pl_ready=0. Next state is PL_GAP.
- PL_GAP:
  - All wenb=0, req_ready=0, pl_ready=0.
  - Next state is IDLE. This guarantees one idle cycle after every preload.
- Retire grant (IDLE, no pl_valid): in-order prefix.
  - req_ready[i]=1 iff req_valid[j]=1 for all j<=i and i<NUM_WP.
  - A hole (valid=0) at lane j blocks all lanes above j.
- Write latency: one cycle. Lanes granted in cycle T appear on the vrf outputs and on rt_uop/rt_last_uop in T+1.
- Bit enable expansion: bit b of register vd = req_be[lane][b/8].
- Same vd in one cycle:
  - Per byte, the highest granted lane with that byte enabled supplies the data.
  - wenb is the OR of the granted lanes' masks.
- Idle cycles: registers not written in a cycle have wenb=0. Data for unwritten registers/bytes is 0.
- rt_uop[i]=1 in T+1 iff lane i was granted in T. rt_last_uop[i] = rt_uop[i] & req_last[i] as sampled at T.
- req_be all-zero on a granted lane: still granted, rt_uop pulses, no write.
- Preload and retire never write in the same cycle.
- Reset mid-preload: returns to IDLE immediately and the preload is dropped. The preload master must re-issue after reset.

Test Plan:
- Reset: assert rst for 3 cycles with pl_valid=1 and req_valid=4'b1111 -> pl_ready=0, req_ready=0, all outputs 0.
- Preload: pl_valid=1, pl_idx=7, pl_data=128'hDEAD_BEEF at cycle T in IDLE, with req_valid=4'b0001 -> req_ready=0 in T.
  - T+1: reg7 wenb=all-ones, data=DEAD_BEEF; req_ready=0.
  - T+2: no writes, req_ready=0.
  - T+3: req_ready[0]=1.
- In-order grant: req_valid=4'b1011, NUM_WP=2 -> req_ready=4'b0011. Next cycle rt_uop=4'b0011.
  - Then req_valid=4'b1010 -> req_ready=4'b0000.
- Same-register merge: lane0 vd=3, be=16'h00FF, data=all 0x11; lane1 vd=3, be=16'h0F0F, data=all 0x22.
  - Next cycle reg3: bytes 0-3 and 8-11 = 0x22; bytes 4-7 = 0x11; wenb bits set for bytes 0-11 only.
- Last flag: lanes 0,1 granted with req_last=2'b10 -> next cycle rt_uop=4'b0011, rt_last_uop=4'b0010.
- Reset in PL_WR: assert rst the cycle after preload accept -> outputs 0 immediately; after deassert, state IDLE and pl_ready=1.
